cram_burst_arbiter: RTL and testbench
=====================================

# cram_burst_arbiter

Two-port arbiter and sequencer in front of the CellularRAM burst controller on the Nexys 3 memory path. It accepts burst read/write requests from two clients: port 0 is the real-time display fetch, port 1 is the general read/write client. It grants one client at a time and issues that client's burst command to the controller. While the burst runs it routes write-data pulls, read data and completion back to the owning port. Port 0 has fixed priority, and a starvation guard bounds how long port 1 can wait.

## Interface
- AW, 20, address width (word address).
- DW, 16, data width.
- LW, 5, burst-length field width; legal lengths 0..16.
- STARVE, 4, maximum consecutive port-0 grants while port 1 is requesting.

- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqN  in  1  port N (N = 0, 1) burst request; held until GntN.
- WriteN  in  1  port N direction (1 = write); held with ReqN.
- AddrN  in  AW  port N start address; held with ReqN.
- LenN  in  LW  port N burst length in words; held with ReqN.
- WrDataN  in  DW  port N write word; next word presented after each WrTakeN.
- GntN  out  1  one-cycle pulse; request accepted, inputs may change next cycle.
- WrTakeN  out  1  port N write word consumed this cycle.
- RdValidN  out  1  RdData holds a port N read word.
- DoneN  out  1  one-cycle pulse; port N burst complete.
- RdData  out  DW  shared read data, qualified by RdValidN.
- Err  out  1  sticky protocol-error flag; cleared only by Reset.
- MemStart  out  1  one-cycle burst command to controller.
- MemWrite, MemAddr[AW], MemLen[LW]  out  registered command fields, stable from MemStart to MemDone.
- MemWrData  out  DW  owner's WrDataN (combinational mux).
- MemBusy  in  1  controller cannot accept a command.
- MemWrTake  in  1  controller consumed MemWrData.
- MemRdValid, MemRdData[DW]  in  read word from controller.
- MemDone  in  1  controller burst finished.

## Operation
- States: IDLE, ISSUE, ACTIVE, FINISH. Owner register holds 0 or 1.
- IDLE: the winner is port 1 if Req1 && (!Req0 || Starve == STARVE); otherwise port 0 if Req0. On a win:
  - latch Write, Addr and Len into the Mem* registers and set Owner;
  - pulse GntOwner next cycle;
  - go to ISSUE, or go to FINISH when Len == 0.
- Len of 17..31 is clamped to 16 at latch time.
- ISSUE: MemStart = !MemBusy. On the cycle MemStart is high, go to ACTIVE. While MemBusy is high, stay in ISSUE with no timeout.
- ACTIVE:
  - WrTakeOwner = MemWrTake, RdValidOwner = MemRdValid, RdData = MemRdData. Non-owner strobes stay 0.
  - A 5-bit beat counter increments on each forwarded MemWrTake or MemRdValid.
  - Beats arriving after count == MemLen are not forwarded, and Err is set.
  - On MemDone: go to FINISH. If count != MemLen, set Err.
- FINISH: pulse DoneOwner and return to IDLE. Starve is updated at the port-0 grant:
  - Starve + 1 (saturating at STARVE) if Req1 was high at that grant;
  - 0 if port 1 was granted or Req1 was low.
- Spurious MemDone, MemWrTake or MemRdValid in IDLE or ISSUE: ignored, not forwarded, Err set.
- A request dropped before its Gnt is legal and is simply not granted.

## Timing
- Reset (async) values: state IDLE, Owner 0, Starve 0, beat counter 0, Err 0, Mem* registers 0. Every output is 0 except MemWrData and RdData, which follow their mux sources.
- Reset mid-burst aborts immediately: no DoneN is issued, and the controller shares the same Reset.
- Req sampled high in IDLE at edge k: GntN and state ISSUE after edge k+1. With MemBusy low, MemStart is high in that same cycle.
- Len == 0: Gnt in cycle k+1, DoneN in cycle k+2, no MemStart.
- DoneN is high the cycle after MemDone. The next grant is sampled in the cycle after DoneN, so back-to-back bursts have 2 idle cycles between MemDone and the next MemStart.
- Strobe forwarding (WrTake, RdValid, RdData) is combinational with zero latency.
- Simultaneous Req0 and Req1 with Starve < STARVE: port 0 wins.

## Test plan
- Req0 read, Addr0 = 0x01234, Len0 = 4, MemBusy = 0 → Gnt0 one cycle later with MemStart, MemAddr = 0x01234, MemLen = 4. Four MemRdValid → four RdValid0 and no RdValid1. MemDone → Done0 next cycle, Err = 0.
- Req0 and Req1 held continuously, Len 2 each → grant sequence 0,0,0,0,1,0,0,0,0,1 with STARVE = 4.
- Req1 write, Len1 = 16, MemBusy high for 5 cycles → MemStart delayed until MemBusy low. 16 WrTake1 pulses; MemWrData tracks WrData1; Done1 after MemDone.
- Len0 = 0 → Gnt0 then Done0 on consecutive cycles, MemStart never asserted. Len1 = 20 → MemLen = 16.
- Protocol errors: MemDone after 3 of 4 beats → Err = 1 and Done still issued. A fifth MemRdValid is not forwarded. A MemRdValid in IDLE → Err, no RdValid.
- Reset asserted mid-write burst → all outputs 0 asynchronously, no DoneN. After release, a Req1 is granted normally with Starve = 0.

Source files
------------

// File: rtl/cram_burst_arbiter.sv
// Two-port burst arbiter in front of the CellularRAM burst controller.
// Port 0 has fixed priority, and a starvation guard bounds how long port 1 waits.
module cram_burst_arbiter #(
  parameter int AW     = 20,
  parameter int DW     = 16,
  parameter int LW     = 5,
  parameter int STARVE = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          Write0,
  input  logic [AW-1:0] Addr0,
  input  logic [LW-1:0] Len0,
  input  logic [DW-1:0] WrData0,
  input  logic          Req1,
  input  logic          Write1,
  input  logic [AW-1:0] Addr1,
  input  logic [LW-1:0] Len1,
  input  logic [DW-1:0] WrData1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          WrTake0,
  output logic          WrTake1,
  output logic          RdValid0,
  output logic          RdValid1,
  output logic          Done0,
  output logic          Done1,
  output logic [DW-1:0] RdData,
  output logic          Err,
  output logic          MemStart,
  output logic          MemWrite,
  output logic [AW-1:0] MemAddr,
  output logic [LW-1:0] MemLen,
  output logic [DW-1:0] MemWrData,
  input  logic          MemBusy,
  input  logic          MemWrTake,
  input  logic          MemRdValid,
  input  logic [DW-1:0] MemRdData,
  input  logic          MemDone
);

  localparam int SW = $clog2(STARVE + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, FINISH} stateT;

  stateT         state;
  logic          owner;
  logic [SW-1:0] starve;
  logic [LW-1:0] beatCount;

  logic          pick1;
  logic          pick0;
  logic          beatIn;
  logic          fwdBeat;
  logic [LW-1:0] countNext;
  logic [LW-1:0] winLen;

  function automatic logic [LW-1:0] clampLen(input logic [LW-1:0] len);
    if (len > LW'(16)) begin
      return LW'(16);
    end else begin
      return len;
    end
  endfunction

  assign pick1     = Req1 && (!Req0 || (starve == SW'(STARVE)));
  assign pick0     = !pick1 && Req0;
  assign winLen    = pick1 ? Len1 : Len0;
  assign beatIn    = MemWrTake || MemRdValid;
  // Beats beyond the programmed length are swallowed rather than forwarded.
  assign fwdBeat   = (state == ACTIVE) && beatIn && (beatCount != MemLen);
  assign countNext = beatCount + LW'(fwdBeat);

  assign WrTake0   = fwdBeat && MemWrTake && !owner;
  assign WrTake1   = fwdBeat && MemWrTake && owner;
  assign RdValid0  = fwdBeat && MemRdValid && !owner;
  assign RdValid1  = fwdBeat && MemRdValid && owner;
  assign RdData    = MemRdData;
  assign MemWrData = owner ? WrData1 : WrData0;
  assign MemStart  = (state == ISSUE) && !MemBusy;

  // Arbitration, command latch, beat accounting and completion sequencing.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      starve    <= '0;
      beatCount <= '0;
      Err       <= 1'b0;
      Gnt0      <= 1'b0;
      Gnt1      <= 1'b0;
      Done0     <= 1'b0;
      Done1     <= 1'b0;
      MemWrite  <= 1'b0;
      MemAddr   <= '0;
      MemLen    <= '0;
    end else begin
      Gnt0 <= 1'b0;
      Gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (beatIn || MemDone) begin
            Err <= 1'b1;
          end
          if (pick1 || pick0) begin
            owner     <= pick1;
            Gnt1      <= pick1;
            Gnt0      <= pick0;
            MemWrite  <= pick1 ? Write1 : Write0;
            MemAddr   <= pick1 ? Addr1 : Addr0;
            MemLen    <= clampLen(winLen);
            beatCount <= '0;
            state     <= (winLen == LW'(0)) ? FINISH : ISSUE;
            // Starve counts consecutive port-0 wins taken while port 1 waited.
            if (pick0 && Req1) begin
              starve <= (starve == SW'(STARVE)) ? starve : starve + SW'(1);
            end else begin
              starve <= '0;
            end
          end
        end
        ISSUE: begin
          if (beatIn || MemDone) begin
            Err <= 1'b1;
          end
          if (!MemBusy) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          beatCount <= countNext;
          if (beatIn && (beatCount == MemLen)) begin
            Err <= 1'b1;
          end
          if (MemDone) begin
            if (countNext != MemLen) begin
              Err <= 1'b1;
            end
            Done0 <= !owner;
            Done1 <= owner;
            state <= FINISH;
          end
        end
        FINISH: begin
          // Zero-length bursts arrive here without a Done pulse and hold one cycle for it.
          if (Done0 || Done1) begin
            Done0 <= 1'b0;
            Done1 <= 1'b0;
            state <= IDLE;
          end else begin
            Done0 <= !owner;
            Done1 <= owner;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cram_burst_arbiter.sv
// Self-checking bench for cram_burst_arbiter: directed scenarios plus randomized
// bursts checked against a spec-level arbitration and beat model.
module tb_cram_burst_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int LW = 5;
  localparam int STARVE = 4;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Req0, Write0, Req1, Write1;
  logic [AW-1:0] Addr0, Addr1;
  logic [LW-1:0] Len0, Len1;
  logic [DW-1:0] WrData0, WrData1;
  logic          Gnt0, Gnt1, WrTake0, WrTake1, RdValid0, RdValid1, Done0, Done1;
  logic [DW-1:0] RdData;
  logic          Err, MemStart, MemWrite;
  logic [AW-1:0] MemAddr;
  logic [LW-1:0] MemLen;
  logic [DW-1:0] MemWrData;
  logic          MemBusy, MemWrTake, MemRdValid, MemDone;
  logic [DW-1:0] MemRdData;

  int errors = 0;
  int checks = 0;
  int modelStarve = 0;
  bit modelErr = 1'b0;

  cram_burst_arbiter #(.AW(AW), .DW(DW), .LW(LW), .STARVE(STARVE)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req0(Req0), .Write0(Write0), .Addr0(Addr0), .Len0(Len0), .WrData0(WrData0),
    .Req1(Req1), .Write1(Write1), .Addr1(Addr1), .Len1(Len1), .WrData1(WrData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .WrTake0(WrTake0), .WrTake1(WrTake1),
    .RdValid0(RdValid0), .RdValid1(RdValid1), .Done0(Done0), .Done1(Done1),
    .RdData(RdData), .Err(Err), .MemStart(MemStart), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemLen(MemLen), .MemWrData(MemWrData),
    .MemBusy(MemBusy), .MemWrTake(MemWrTake), .MemRdValid(MemRdValid),
    .MemRdData(MemRdData), .MemDone(MemDone)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int clampLen(input int l);
    return (l > 16) ? 16 : l;
  endfunction

  function automatic int predictWinner(input bit r0, input bit r1);
    if (r1 && (!r0 || modelStarve == STARVE)) return 1;
    if (r0) return 0;
    return -1;
  endfunction

  task automatic nextCycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic clearInputs();
    Req0 = 1'b0; Write0 = 1'b0; Addr0 = '0; Len0 = '0; WrData0 = '0;
    Req1 = 1'b0; Write1 = 1'b0; Addr1 = '0; Len1 = '0; WrData1 = '0;
    MemBusy = 1'b0; MemWrTake = 1'b0; MemRdValid = 1'b0; MemRdData = '0; MemDone = 1'b0;
  endtask

  task automatic applyReset();
    clearInputs();
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    modelStarve = 0;
    modelErr = 1'b0;
  endtask

  task automatic driveReq(input int p, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    if (p == 0) begin
      Req0 = 1'b1; Write0 = wr; Addr0 = a; Len0 = l;
    end else begin
      Req1 = 1'b1; Write1 = wr; Addr1 = a; Len1 = l;
    end
  endtask

  // Runs one burst for the predicted winner from grant to Done, checking each phase.
  task automatic serveBurst(input int port, input int busy, input int beats, input bit holdReq);
    int            expLen;
    bit            expWr;
    bit            r1AtGrant;
    logic [AW-1:0] expAddr;
    logic [LW-1:0] expLenV;
    logic [1:0]    expPair;
    logic [3:0]    expStrobes;
    logic [3:0]    gotStrobes;
    expLen    = clampLen(int'(port ? Len1 : Len0));
    expLenV   = LW'(expLen);
    expWr     = port ? Write1 : Write0;
    expAddr   = port ? Addr1 : Addr0;
    expPair   = port ? 2'b10 : 2'b01;
    r1AtGrant = Req1;
    MemBusy   = (busy > 0);
    nextCycle();
    checks++;
    if ({Gnt1, Gnt0} !== expPair) begin
      errors++;
      $display("FAIL grant: got Gnt1/Gnt0=%b want %b", {Gnt1, Gnt0}, expPair);
    end
    checks++;
    if (MemAddr !== expAddr || MemLen !== expLenV || MemWrite !== expWr) begin
      errors++;
      $display("FAIL command: got addr=%h len=%0d wr=%b want addr=%h len=%0d wr=%b",
               MemAddr, MemLen, MemWrite, expAddr, expLenV, expWr);
    end
    if (port == 1 || !r1AtGrant) modelStarve = 0;
    else if (modelStarve < STARVE) modelStarve++;
    if (!holdReq) begin
      if (port == 0) Req0 = 1'b0; else Req1 = 1'b0;
    end
    if (port == 0) Addr0 = AW'($urandom); else Addr1 = AW'($urandom);
    if (expLen == 0) begin
      #1;
      checks++;
      if (MemStart !== 1'b0) begin
        errors++;
        $display("FAIL zero_len_start: got MemStart=%b want 0", MemStart);
      end
      nextCycle();
      checks++;
      if ({Done1, Done0} !== expPair || MemStart !== 1'b0) begin
        errors++;
        $display("FAIL zero_len_done: got Done=%b start=%b want %b start=0", {Done1, Done0}, MemStart, expPair);
      end
      nextCycle();
      checks++;
      if ({Done1, Done0} !== 2'b00) begin
        errors++;
        $display("FAIL done_pulse: got Done=%b want 00", {Done1, Done0});
      end
      return;
    end
    for (int i = 0; i < busy; i++) begin
      #1;
      checks++;
      if (MemStart !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold: got MemStart=%b want 0 (busy cycle %0d)", MemStart, i);
      end
      nextCycle();
    end
    MemBusy = 1'b0;
    #1;
    checks++;
    if (MemStart !== 1'b1) begin
      errors++;
      $display("FAIL issue: got MemStart=%b want 1", MemStart);
    end
    nextCycle();
    checks++;
    if ({Gnt1, Gnt0, MemStart} !== 3'b000) begin
      errors++;
      $display("FAIL one_shot: got Gnt=%b start=%b want 00 0", {Gnt1, Gnt0}, MemStart);
    end
    for (int b = 0; b < beats; b++) begin
      if (expWr) MemWrTake = 1'b1; else MemRdValid = 1'b1;
      MemRdData = DW'($urandom);
      WrData0 = DW'($urandom);
      WrData1 = DW'($urandom);
      #1;
      expStrobes = 4'b0000;
      if (b < expLen) begin
        if (expWr) expStrobes[2 + port] = 1'b1;
        else expStrobes[port] = 1'b1;
      end
      gotStrobes = {WrTake1, WrTake0, RdValid1, RdValid0};
      checks++;
      if (gotStrobes !== expStrobes || RdData !== MemRdData) begin
        errors++;
        $display("FAIL beat%0d: got wt1/wt0/rv1/rv0=%b rd=%h want %b rd=%h",
                 b, gotStrobes, RdData, expStrobes, MemRdData);
      end
      if (expWr) begin
        checks++;
        if (MemWrData !== (port ? WrData1 : WrData0)) begin
          errors++;
          $display("FAIL wrdata%0d: got %h want %h", b, MemWrData, port ? WrData1 : WrData0);
        end
      end
      nextCycle();
      MemWrTake = 1'b0;
      MemRdValid = 1'b0;
      if ($urandom_range(0, 1) == 1) nextCycle();
    end
    MemDone = 1'b1;
    nextCycle();
    MemDone = 1'b0;
    if (beats != expLen) modelErr = 1'b1;
    checks++;
    if ({Done1, Done0} !== expPair || Err !== modelErr) begin
      errors++;
      $display("FAIL done: got Done=%b Err=%b want %b Err=%b", {Done1, Done0}, Err, expPair, modelErr);
    end
    nextCycle();
    checks++;
    if ({Done1, Done0} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse: got Done=%b want 00", {Done1, Done0});
    end
  endtask

  task automatic test_reset();
    clearInputs();
    Reset = 1'b1;
    #1;
    checks++;
    if ({Gnt0, Gnt1, WrTake0, WrTake1, RdValid0, RdValid1, Done0, Done1, Err, MemStart, MemWrite} !== 11'd0 ||
        MemAddr !== '0 || MemLen !== '0) begin
      errors++;
      $display("FAIL reset: outputs not all zero (addr=%h len=%0d err=%b)", MemAddr, MemLen, Err);
    end
    applyReset();
    checks++;
    if ({Gnt0, Gnt1, Done0, Done1, Err, MemStart} !== 6'd0) begin
      errors++;
      $display("FAIL reset_release: got gnt/done/err/start=%b want 0", {Gnt0, Gnt1, Done0, Done1, Err, MemStart});
    end
  endtask

  task automatic test_read_burst();
    driveReq(0, 1'b0, 20'h01234, 5'd4);
    serveBurst(0, 0, 4, 1'b0);
  endtask

  task automatic test_starvation();
    int seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    driveReq(0, 1'b0, 20'h00100, 5'd2);
    driveReq(1, 1'b0, 20'h00200, 5'd2);
    for (int i = 0; i < 10; i++) begin
      serveBurst(seq[i], 0, 2, 1'b1);
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
  endtask

  task automatic test_busy_write();
    driveReq(1, 1'b1, 20'hABCDE, 5'd16);
    serveBurst(1, 5, 16, 1'b0);
  endtask

  task automatic test_zero_and_clamp();
    driveReq(0, 1'b0, 20'h00042, 5'd0);
    serveBurst(0, 0, 0, 1'b0);
    driveReq(1, 1'b0, 20'h00777, 5'd20);
    serveBurst(1, 0, 16, 1'b0);
  endtask

  task automatic test_random();
    int w;
    bit r0, r1;
    for (int it = 0; it < 24; it++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r1 = 1'b1;
      Req0 = r0; Write0 = 1'($urandom); Addr0 = AW'($urandom); Len0 = LW'($urandom_range(0, 20));
      Req1 = r1; Write1 = 1'($urandom); Addr1 = AW'($urandom); Len1 = LW'($urandom_range(0, 20));
      w = predictWinner(r0, r1);
      serveBurst(w, $urandom_range(0, 3), clampLen(int'(w ? Len1 : Len0)), 1'b0);
      Req0 = 1'b0;
      Req1 = 1'b0;
    end
  endtask

  task automatic test_protocol_errors();
    applyReset();
    MemRdValid = 1'b1;
    #1;
    checks++;
    if ({RdValid1, RdValid0} !== 2'b00) begin
      errors++;
      $display("FAIL idle_spurious_fwd: got RdValid=%b want 00", {RdValid1, RdValid0});
    end
    nextCycle();
    MemRdValid = 1'b0;
    checks++;
    if (Err !== 1'b1) begin
      errors++;
      $display("FAIL idle_spurious_err: got Err=%b want 1", Err);
    end
    applyReset();
    driveReq(0, 1'b0, 20'h00300, 5'd4);
    serveBurst(0, 0, 3, 1'b0);
    applyReset();
    driveReq(0, 1'b0, 20'h00400, 5'd4);
    serveBurst(0, 0, 5, 1'b0);
  endtask

  task automatic test_mid_reset();
    applyReset();
    driveReq(1, 1'b1, 20'h05555, 5'd8);
    nextCycle();
    Req1 = 1'b0;
    nextCycle();
    for (int b = 0; b < 3; b++) begin
      MemWrTake = 1'b1;
      nextCycle();
      MemWrTake = 1'b0;
    end
    MemWrTake = 1'b1;
    #1;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Gnt0, Gnt1, WrTake0, WrTake1, RdValid0, RdValid1, Done0, Done1, Err, MemStart, MemWrite} !== 11'd0 ||
        MemAddr !== '0 || MemLen !== '0) begin
      errors++;
      $display("FAIL mid_reset: got wt1=%b addr=%h len=%0d wr=%b want all 0", WrTake1, MemAddr, MemLen, MemWrite);
    end
    MemWrTake = 1'b0;
    nextCycle();
    Reset = 1'b0;
    modelStarve = 0;
    modelErr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checks++;
      if ({Done1, Done0} !== 2'b00) begin
        errors++;
        $display("FAIL no_done_after_reset: got Done=%b want 00", {Done1, Done0});
      end
    end
    driveReq(1, 1'b0, 20'h06666, 5'd3);
    serveBurst(1, 0, 3, 1'b0);
    driveReq(0, 1'b0, 20'h07777, 5'd1);
    driveReq(1, 1'b0, 20'h08888, 5'd1);
    serveBurst(predictWinner(1'b1, 1'b1), 0, 1, 1'b0);
    Req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_starvation();
    test_busy_write();
    test_zero_and_clamp();
    test_random();
    test_protocol_errors();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
